field_packer: RTL
=================

FIELD_PACKER -- requirements
Module: field_packer

Interface
REQ-001 SHALL have parameter FIELD_W, default 12, bit width of one input field (>=1).
REQ-002 SHALL have parameter N_FIELDS, default 4, fields per packed word (>=2).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  field offered.
REQ-006 SHALL have port in_ready  output  1  field accepted when in_valid && in_ready.
REQ-007 SHALL have port in_data  input  FIELD_W  field value.
REQ-008 SHALL have port in_last  input  1  accepted field closes the word early.
REQ-009 SHALL have port out_valid  output  1  packed word available.
REQ-010 SHALL have port out_ready  input  1  word consumed when out_valid && out_ready.
REQ-011 SHALL have port out_data  output  FIELD_W*N_FIELDS  packed word.
REQ-012 SHALL have port out_count  output  $clog2(N_FIELDS+1)  number of fields in out_data.

Function
REQ-013 SHALL implement two states: FILL (collecting fields) and HOLD (word presented).
REQ-014 SHALL keep a slot index 0..N_FIELDS-1 that increments on every accepted field in FILL.
REQ-015 SHALL write an accepted field into its slot; default order is MSB-first: slot 0 at out_data[FIELD_W*N_FIELDS-1 -: FIELD_W], matching {f0,f1,...}.
REQ-016 SHALL transition FILL->HOLD on acceptance of slot N_FIELDS-1 or of any field with in_last=1; out_valid asserts the following cycle (1-cycle latency).
REQ-017 SHALL zero every slot not written in the current word (early in_last pads with zeros).
REQ-018 SHALL set out_count to the number of fields accepted in the word (1..N_FIELDS).
REQ-019 SHALL drive in_ready = (state==FILL) || (state==HOLD && out_ready).
REQ-020 SHALL hold out_data and out_count stable while out_valid && !out_ready.
REQ-021 SHALL, on HOLD with out_ready=1: return to FILL with index 0; if a field is accepted in the same cycle, place it in slot 0 of the new word (no bubble), zero the remaining slots.
REQ-022 SHALL, on the same-cycle case of REQ-021 with N_FIELDS... in_last=1, go directly to HOLD with out_count=1.
REQ-023 SHALL ignore in_data/in_last whenever in_valid=0 or in_ready=0.

Reset
REQ-024 SHALL, on rst_n=0 at any time: state=FILL, index=0, out_valid=0, out_data=0, out_count=0, in_ready=1 after release.
REQ-025 SHALL discard any partially collected word on reset; first field after release goes to slot 0.

Configuration
REQ-026 SHALL honour macro FIELD_PACKER_LSB_FIRST_EN: defined -> slot 0 at out_data[FIELD_W-1:0], slot k at bits [k*FIELD_W +: FIELD_W]; undefined -> MSB-first per REQ-015. Padding, count and handshake unchanged.

Structure
REQ-027 SHALL place the state enum (FILL, HOLD) and a count-width helper constant in package field_packer_pkg.
REQ-028 SHALL be a single module; no sub-module is warranted.

Verification (FIELD_W=12, N_FIELDS=4)
REQ-029 SHALL check: fields 0xABC,0x123,0x456,0x789, out_ready=1 -> out_data=0xABC123456789, out_count=4, out_valid one cycle after last accept.
REQ-030 SHALL check: 0x111, then 0x222 with in_last=1 -> out_data=0x111222000000, out_count=2.
REQ-031 SHALL check: out_ready=0 for 3 cycles in HOLD -> out_data stable, in_ready=0, in_valid fields not consumed.
REQ-032 SHALL check: HOLD with out_ready=1 and in_valid=1 data 0xFFF -> word handed off and 0xFFF lands in slot 0 of next word, no idle cycle.
REQ-033 SHALL check: rst_n pulsed low after 2 fields accepted -> out_valid=0, out_count=0; next 4 fields 0x001..0x004 -> out_data=0x001002003004.
REQ-034 SHALL check with FIELD_PACKER_LSB_FIRST_EN defined: sequence of REQ-029 -> out_data=0x789456123ABC.

Source files
------------

// File: rtl/field_packer_pkg.sv
// Shared types and sizing helpers for the field packer.
// State encoding plus the width helper used for the field-count output.
package field_packer_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Bits needed to hold a count of 0..n_fields inclusive.
  function automatic int unsigned count_w(input int unsigned n_fields);
    return $clog2(n_fields + 1);
  endfunction

endpackage

// File: rtl/field_packer.sv
// Packs FIELD_W-bit fields into N_FIELDS-slot words with early close on in_last.
// Define FIELD_PACKER_LSB_FIRST_EN to place slot 0 in the low bits instead of the high bits.
module field_packer
  import field_packer_pkg::*;
#(
  parameter int FIELD_W  = 12,
  parameter int N_FIELDS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [FIELD_W-1:0]            in_data,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [FIELD_W*N_FIELDS-1:0]   out_data,
  output logic [$clog2(N_FIELDS+1)-1:0] out_count
);

  localparam int WORD_W = FIELD_W * N_FIELDS;
  localparam int IDX_W  = $clog2(N_FIELDS);
  localparam int CNT_W  = count_w(N_FIELDS);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [WORD_W-1:0]  word;
  logic [CNT_W-1:0]   count;
  logic               valid_q;
  logic               accept;
  logic               last_slot;
  logic [CNT_W-1:0]   count_next;

  // Returns a word holding only field f in the given slot, all other bits zero.
  function automatic logic [WORD_W-1:0] place(input logic [FIELD_W-1:0] f,
                                              input logic [IDX_W-1:0]   slot);
    logic [WORD_W-1:0] res;
    int lo;
    res = '0;
    for (int k = 0; k < N_FIELDS; k++) begin
`ifdef FIELD_PACKER_LSB_FIRST_EN
      lo = k * FIELD_W;
`else
      lo = (N_FIELDS - 1 - k) * FIELD_W;
`endif
      if (slot == IDX_W'(k)) res[lo +: FIELD_W] = f;
    end
    return res;
  endfunction

  // A held word can be handed off and a new field taken in the same cycle.
  assign in_ready   = (state == FILL) || (state == HOLD && out_ready);
  assign accept     = in_valid && in_ready;
  assign last_slot  = (idx == IDX_W'(N_FIELDS - 1));
  assign count_next = CNT_W'(idx) + CNT_W'(1);

  assign out_valid  = valid_q;
  assign out_data   = word;
  assign out_count  = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FILL;
      idx     <= '0;
      word    <= '0;
      count   <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state)
        FILL: begin
          if (accept) begin
            // Slot 0 starts a fresh word, so every other slot is cleared here.
            word  <= (idx == '0) ? place(in_data, idx) : (word | place(in_data, idx));
            count <= count_next;
            if (last_slot || in_last) begin
              state   <= HOLD;
              valid_q <= 1'b1;
              idx     <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (accept) begin
              word  <= place(in_data, IDX_W'(0));
              count <= CNT_W'(1);
              if (in_last) begin
                state   <= HOLD;
                valid_q <= 1'b1;
                idx     <= '0;
              end else begin
                state   <= FILL;
                valid_q <= 1'b0;
                idx     <= IDX_W'(1);
              end
            end else begin
              state   <= FILL;
              valid_q <= 1'b0;
              idx     <= '0;
              count   <= '0;
            end
          end
        end
        default: begin
          state   <= FILL;
          valid_q <= 1'b0;
          idx     <= '0;
        end
      endcase
    end
  end

endmodule
